test_sequencer: RTL and testbench
=================================

Name: test_sequencer

Overview:
- Parametrised, synthesizable sequencer for the processor test suite.
- Runs NUM_TESTS test channels one at a time, in index order.
- For each channel it issues a one-cycle start pulse, waits for a done/pass handshake or a timeout, then records the outcome.
- Aggregated pass/fail/timeout status replaces the static list of test instances at the testbench top, so that any number of component or instruction tests can run under one self-checking controller.

Parameters:
- NUM_TESTS, 8, number of test channels (>=1).
- TIMEOUT_CYCLES, 64, maximum WAIT cycles per test before a forced fail (>=2).
- IDX_W, $clog2(NUM_TESTS) (min 1), width of test index.
- CNT_W, $clog2(NUM_TESTS+1), width of pass/fail counters.
- TMR_W, $clog2(TIMEOUT_CYCLES), width of timeout timer.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- run  input  1  level-sampled start request; acted on only in IDLE or DONE.
- skip_mask  input  NUM_TESTS  bit k=1: channel k is skipped (never started, counted in neither counter); sampled per test in START.
- test_start  output  NUM_TESTS  one-hot start pulse to the current channel.
- test_done  input  NUM_TESTS  per-channel completion; only the current channel is observed.
- test_pass  input  NUM_TESTS  per-channel verdict; valid with test_done.
- busy  output  1  high in START/WAIT/NEXT.
- finished  output  1  high in DONE.
- all_passed  output  1  finished && fail_count==0.
- current_test  output  IDX_W  index of the channel in progress.
- pass_count  output  CNT_W  tests passed.
- fail_count  output  CNT_W  tests failed, including timeouts.
- fail_mask  output  NUM_TESTS  bit k set if channel k failed.
- timeout_mask  output  NUM_TESTS  bit k set if channel k timed out (subset of fail_mask).

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0; idx=0; timer=0. A reset mid-run drops test_start the same instant and discards all results.
- FSM states: IDLE, START, WAIT, NEXT, DONE.
- IDLE: run=1 at a rising edge -> START with idx=0. Counters and masks are already 0.
- START, one cycle:
  - If skip_mask[idx]=1: test_start stays 0 and the next state is NEXT.
  - Otherwise test_start[idx]=1 for exactly this cycle; timer cleared; next state is WAIT.
- WAIT:
  - test_done is first sampled at the edge ending the first WAIT cycle. test_done asserted during START is ignored.
  - test_done[idx]=1: record result at that edge; test_pass[idx]=1 -> pass_count+1, else fail_count+1 and fail_mask[idx]=1. Next state is NEXT.
  - Otherwise timer+1. On the edge where timer==TIMEOUT_CYCLES-1 with done still low: fail_count+1, fail_mask[idx]=1, timeout_mask[idx]=1, next state is NEXT.
  - done and timeout on the same edge: done wins (normal result, no timeout bit).
- NEXT, one cycle: idx==NUM_TESTS-1 -> DONE; else idx+1 -> START.
- DONE: finished=1; results held. run=1 -> clear counters, masks and idx, then go to START (re-run). current_test holds the last index.
- run while busy is ignored.
- test_done/test_pass from non-current channels are ignored in every state.
- Counters cannot overflow: CNT_W covers NUM_TESTS.
- Per-test latency, non-skipped: 1 (START) + d (WAIT, 1<=d<=TIMEOUT_CYCLES) + 1 (NEXT) cycles. A skipped test takes 2 cycles.
- With run=1 sampled at edge 0, test_start[0] is high in the cycle after edge 0.
- All outputs are registered; no combinational input-to-output paths, except that all_passed is decoded from registered state.

Test Plan (NUM_TESTS=4, TIMEOUT_CYCLES=16):
1. Reset, pulse run. Each channel answers done=1, pass=1 exactly 3 cycles after its start -> starts are one-hot and 5 cycles apart; finished=1 after 20 cycles; pass_count=4, fail_count=0, all_passed=1.
2. Channel 2 returns pass=0 -> fail_mask=4'b0100, timeout_mask=0, pass_count=3, fail_count=1, all_passed=0.
3. Channel 1 never asserts done -> after 16 WAIT cycles timeout_mask=fail_mask=4'b0010; sequence continues to channel 2; fail_count=1.
4. skip_mask=4'b1001 -> test_start[0] and test_start[3] are never asserted; pass_count=2, fail_count=0, run length 2+5+5+2 cycles.
5. Spurious done on channel 3 while channel 0 waits, and done asserted during START -> both ignored. Done on the 16th WAIT cycle counts as pass, no timeout bit.
6. Assert reset during WAIT of channel 1 -> test_start drops immediately; all outputs 0; IDLE. A subsequent run restarts from channel 0 with clean counters. Run while busy does nothing; run in DONE clears results and re-runs.

Source files
------------

// File: rtl/test_sequencer.sv
// Sequential test-channel controller: starts each channel in index order, waits for
// done/pass or a timeout, and aggregates pass/fail/timeout results.
module test_sequencer #(
    parameter int NUM_TESTS      = 8,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int IDX_W          = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
    parameter int CNT_W          = $clog2(NUM_TESTS + 1),
    parameter int TMR_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic [NUM_TESTS-1:0] skip_mask,
    output logic [NUM_TESTS-1:0] test_start,
    input  logic [NUM_TESTS-1:0] test_done,
    input  logic [NUM_TESTS-1:0] test_pass,
    output logic                 busy,
    output logic                 finished,
    output logic                 all_passed,
    output logic [IDX_W-1:0]     current_test,
    output logic [CNT_W-1:0]     pass_count,
    output logic [CNT_W-1:0]     fail_count,
    output logic [NUM_TESTS-1:0] fail_mask,
    output logic [NUM_TESTS-1:0] timeout_mask
);

    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_NEXT, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic [CNT_W-1:0]     pass_q, pass_d, fail_q, fail_d;
    logic [NUM_TESTS-1:0] fmask_q, fmask_d, tmask_q, tmask_d;
    logic [NUM_TESTS-1:0] start_q, start_d;
    logic                 busy_q, busy_d, fin_q, fin_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        fmask_d = fmask_q;
        tmask_d = tmask_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (run) begin
                    state_d = S_START;
                    idx_d   = '0;
                    pass_d  = '0;
                    fail_d  = '0;
                    fmask_d = '0;
                    tmask_d = '0;
                end
            end
            S_START: begin
                // Skip decision was taken when entering START and is reflected in the pulse.
                tmr_d   = '0;
                state_d = start_q[idx_q] ? S_WAIT : S_NEXT;
            end
            S_WAIT: begin
                if (test_done[idx_q]) begin
                    if (test_pass[idx_q]) begin
                        pass_d = pass_q + CNT_W'(1);
                    end else begin
                        fail_d         = fail_q + CNT_W'(1);
                        fmask_d[idx_q] = 1'b1;
                    end
                    state_d = S_NEXT;
                end else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    fail_d         = fail_q + CNT_W'(1);
                    fmask_d[idx_q] = 1'b1;
                    tmask_d[idx_q] = 1'b1;
                    state_d        = S_NEXT;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_NEXT: begin
                if (idx_q == IDX_W'(NUM_TESTS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_START;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are computed from the next state so they line up with the state register.
        start_d = '0;
        if (state_d == S_START && !skip_mask[idx_d]) start_d[idx_d] = 1'b1;
        busy_d = (state_d == S_START) || (state_d == S_WAIT) || (state_d == S_NEXT);
        fin_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            tmr_q   <= '0;
            pass_q  <= '0;
            fail_q  <= '0;
            fmask_q <= '0;
            tmask_q <= '0;
            start_q <= '0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            fmask_q <= fmask_d;
            tmask_q <= tmask_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
        end
    end

    assign test_start   = start_q;
    assign busy         = busy_q;
    assign finished     = fin_q;
    assign all_passed   = fin_q && (fail_q == '0);
    assign current_test = idx_q;
    assign pass_count   = pass_q;
    assign fail_count   = fail_q;
    assign fail_mask    = fmask_q;
    assign timeout_mask = tmask_q;

endmodule

// File: tb/tb_test_sequencer.sv
// Table-driven bench for test_sequencer: a channel responder plus a start-event scoreboard
// checked against a cycle model of the run schedule.
module tb_test_sequencer;

    localparam int N  = 4;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         run = 1'b0;
    logic [N-1:0] skip_mask = '0;
    logic [N-1:0] test_start;
    logic [N-1:0] test_done = '0;
    logic [N-1:0] test_pass = '0;
    logic         busy, finished, all_passed;
    logic [1:0]   current_test;
    logic [2:0]   pass_count, fail_count;
    logic [N-1:0] fail_mask, timeout_mask;

    test_sequencer #(.NUM_TESTS(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .run(run), .skip_mask(skip_mask),
        .test_start(test_start), .test_done(test_done), .test_pass(test_pass),
        .busy(busy), .finished(finished), .all_passed(all_passed),
        .current_test(current_test), .pass_count(pass_count), .fail_count(fail_count),
        .fail_mask(fail_mask), .timeout_mask(timeout_mask)
    );

    always #5 clk = ~clk;

    // dly[k]: cycles from start to done (0 = never answers); pas[k]: verdict
    typedef struct {
        logic [N-1:0]      skip;
        logic [N-1:0][4:0] dly;
        logic [N-1:0]      pas;
        bit                spur;
        int                hold;
        int                exp_pass;
        int                exp_fail;
        logic [N-1:0]      exp_fm;
        logic [N-1:0]      exp_tm;
    } scn_t;

    typedef struct {
        int ch;
        int cyc;
    } sb_t;

    sb_t sbq[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic scn_t mk(input logic [N-1:0] skip, input logic [N-1:0][4:0] dly,
                                input logic [N-1:0] pas, input bit spur, input int hold,
                                input int ep, input int ef, input logic [N-1:0] fm,
                                input logic [N-1:0] tm);
        scn_t s;
        s.skip = skip; s.dly = dly; s.pas = pas; s.spur = spur; s.hold = hold;
        s.exp_pass = ep; s.exp_fail = ef; s.exp_fm = fm; s.exp_tm = tm;
        return s;
    endfunction

    task automatic run_scn(input scn_t s, input string tag);
        int  st[N];
        bit  act[N];
        int  t, cyc, fin_cyc;
        bit  fin;
        sb_t e;
        // schedule model: skipped test 2 cycles, otherwise START + WAIT + NEXT
        t = 1;
        for (int k = 0; k < N; k++) begin
            act[k] = 1'b0;
            st[k]  = 0;
            if (s.skip[k]) begin
                t += 2;
            end else begin
                e.ch = k; e.cyc = t;
                sbq.push_back(e);
                t += ((s.dly[k] == 0) ? TO : int'(s.dly[k])) + 2;
            end
        end
        skip_mask = s.skip;
        run = 1'b1;
        @(posedge clk); #1;
        cyc = 1; fin = 1'b0; fin_cyc = 0;
        while (!fin && cyc <= t + 4) begin
            if (cyc >= s.hold) run = 1'b0;
            if (cyc == 1) begin
                chk({tag, " busy_at_start"}, {31'b0, busy}, 32'd1);
                chk({tag, " cleared_at_start"}, {pass_count, fail_count, fail_mask, timeout_mask}, 32'd0);
            end
            test_done = '0;
            test_pass = '0;
            if (test_start != '0) begin
                if (sbq.size() == 0) begin
                    chk({tag, " unexpected_start"}, {28'b0, test_start}, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk({tag, " start_onehot"}, {28'b0, test_start}, 32'd1 << e.ch);
                    chk({tag, " start_cycle"}, cyc, e.cyc);
                    st[e.ch]  = cyc;
                    act[e.ch] = 1'b1;
                    if (s.spur) test_done[e.ch] = 1'b1;
                end
            end
            for (int k = 0; k < N; k++) begin
                if (act[k] && s.dly[k] != 0 && cyc == st[k] + int'(s.dly[k])) begin
                    test_done[k] = 1'b1;
                    test_pass[k] = s.pas[k];
                end
            end
            if (s.spur && act[0] && cyc == st[0] + 2) test_done[3] = 1'b1;
            if (finished) begin
                fin = 1'b1;
                fin_cyc = cyc;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        test_done = '0;
        test_pass = '0;
        run = 1'b0;
        chk({tag, " finish_cycle"}, fin_cyc, t);
        chk({tag, " starts_left"}, sbq.size(), 0);
        sbq.delete();
        chk({tag, " pass_count"}, {29'b0, pass_count}, s.exp_pass);
        chk({tag, " fail_count"}, {29'b0, fail_count}, s.exp_fail);
        chk({tag, " fail_mask"}, {28'b0, fail_mask}, {28'b0, s.exp_fm});
        chk({tag, " timeout_mask"}, {28'b0, timeout_mask}, {28'b0, s.exp_tm});
        chk({tag, " all_passed"}, {31'b0, all_passed}, (s.exp_fail == 0) ? 32'd1 : 32'd0);
        chk({tag, " idle_flags"}, {29'b0, busy, finished, current_test == 2'd3}, 32'b011);
    endtask

    scn_t tbl[6];

    initial begin
        //                 skip     dly ch3..ch0                    pas     spur hold  P  F  fm       tm
        tbl[0] = mk(4'b0000, {5'd3, 5'd3, 5'd3, 5'd3},   4'b1111, 1'b0, 1, 4, 0, 4'b0000, 4'b0000);
        tbl[1] = mk(4'b0000, {5'd3, 5'd3, 5'd3, 5'd3},   4'b1011, 1'b0, 1, 3, 1, 4'b0100, 4'b0000);
        tbl[2] = mk(4'b0000, {5'd3, 5'd3, 5'd0, 5'd3},   4'b1111, 1'b0, 1, 3, 1, 4'b0010, 4'b0010);
        tbl[3] = mk(4'b1001, {5'd3, 5'd3, 5'd3, 5'd3},   4'b1111, 1'b0, 6, 2, 0, 4'b0000, 4'b0000);
        tbl[4] = mk(4'b0000, {5'd3, 5'd3, 5'd3, 5'd16},  4'b1111, 1'b1, 1, 4, 0, 4'b0000, 4'b0000);
        tbl[5] = mk(4'b0000, {5'd2, 5'd0, 5'd16, 5'd1},  4'b1010, 1'b0, 9, 2, 2, 4'b0101, 4'b0100);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {test_start, busy, finished, all_passed, current_test, pass_count,
                              fail_count, fail_mask, timeout_mask}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_no_start", {27'b0, test_start, busy}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_scn(tbl[i], $sformatf("scn%0d", i));
        end

        // reset while channel 1 waits: ch1 START is cycle 6, WAIT cycles 7..9
        skip_mask = '0;
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        for (int c = 1; c < 8; c++) begin
            if (c == 4) test_done[0] = 1'b1;
            if (c == 4) test_pass[0] = 1'b1;
            @(posedge clk); #1;
            test_done = '0;
            test_pass = '0;
        end
        chk("pre_reset_pass", {29'b0, pass_count}, 32'd1);
        chk("pre_reset_idx", {30'b0, current_test}, 32'd1);
        reset = 1'b1;
        #1;
        chk("midrun_reset", {test_start, busy, finished, all_passed, current_test, pass_count,
                             fail_count, fail_mask, timeout_mask}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_idle", {27'b0, test_start, busy}, 32'd0);
        run_scn(tbl[0], "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
